// File: rtl/opb_register_ppc2user.sv
// OPB slave holding one 32-bit control word written by software and read by fabric logic.
// The whole address window aliases the single register; every hit is acknowledged one cycle later.
module opb_register_ppc2user #(
    parameter logic [31:0] C_BASEADDR    = 32'h0100_E200,
    parameter logic [31:0] C_HIGHADDR    = 32'h0100_E2FF,
    parameter int          C_OPB_AWIDTH  = 32,
    parameter int          C_OPB_DWIDTH  = 32,
    parameter logic [31:0] C_RESET_VALUE = 32'h0000_0000
) (
    input  logic                     OPB_Clk,
    input  logic                     OPB_Rst_n,
    input  logic [0:C_OPB_AWIDTH-1]  OPB_ABus,
    input  logic [0:3]               OPB_BE,
    input  logic [0:C_OPB_DWIDTH-1]  OPB_DBus,
    input  logic                     OPB_RNW,
    input  logic                     OPB_select,
    input  logic                     OPB_seqAddr,
    output logic [0:C_OPB_DWIDTH-1]  Sl_DBus,
    output logic                     Sl_xferAck,
    output logic                     Sl_errAck,
    output logic                     Sl_retry,
    output logic                     Sl_toutSup,
    output logic [31:0]              user_data_out,
    output logic                     user_data_valid
);

    typedef enum logic {
        IDLE = 1'b0,
        ACK  = 1'b1
    } state_t;

    state_t        state_reg, state_next;
    logic [1:0]    rst_sync_reg;
    logic          rst_n_int;
    logic          hit;
    logic [31:0]   merged_word;
    logic [31:0]   data_reg, data_next;
    logic [31:0]   rdata_reg, rdata_next;
    logic          ack_reg, ack_next;
    logic          valid_reg, valid_next;
    logic          unused_seq_addr;

    // Sequential-burst hint is irrelevant: every beat is acknowledged on its own.
    assign unused_seq_addr = OPB_seqAddr;

    // Reset asserts immediately but is released only on a clock edge.
    always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
        if (!OPB_Rst_n) begin
            rst_sync_reg <= 2'b00;
        end else begin
            rst_sync_reg <= {rst_sync_reg[0], 1'b1};
        end
    end

    assign rst_n_int = rst_sync_reg[1];

    assign hit = OPB_select && (OPB_ABus >= C_BASEADDR) && (OPB_ABus <= C_HIGHADDR);

    // Byte lane k of the bus (DBus[8k:8k+7], big-endian) maps onto user bits [31-8k -: 8].
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign merged_word[31-8*gi -: 8] = OPB_BE[gi] ? OPB_DBus[8*gi +: 8]
                                                          : data_reg[31-8*gi -: 8];
        end
    endgenerate

    always_comb begin
        state_next = state_reg;
        data_next  = data_reg;
        rdata_next = 32'h0000_0000;
        ack_next   = 1'b0;
        valid_next = 1'b0;
        case (state_reg)
            IDLE: begin
                if (hit) begin
                    state_next = ACK;
                    ack_next   = 1'b1;
                    if (OPB_RNW) begin
                        rdata_next = data_reg;
                    end else begin
                        data_next  = merged_word;
                        valid_next = |OPB_BE;
                    end
                end
            end
            ACK: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge OPB_Clk or negedge rst_n_int) begin
        if (!rst_n_int) begin
            state_reg <= IDLE;
            data_reg  <= C_RESET_VALUE;
            rdata_reg <= 32'h0000_0000;
            ack_reg   <= 1'b0;
            valid_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            data_reg  <= data_next;
            rdata_reg <= rdata_next;
            ack_reg   <= ack_next;
            valid_reg <= valid_next;
        end
    end

    assign Sl_DBus         = rdata_reg;
    assign Sl_xferAck      = ack_reg;
    assign Sl_errAck       = 1'b0;
    assign Sl_retry        = 1'b0;
    assign Sl_toutSup      = 1'b0;
    assign user_data_out   = data_reg;
    assign user_data_valid = valid_reg;

endmodule

// File: tb/tb_opb_register_ppc2user.sv
// Scoreboard bench for opb_register_ppc2user: expectations are queued at drive time and
// retired when the slave acknowledges; idle cycles are checked for a quiet bus.
module tb_opb_register_ppc2user;

    localparam logic [31:0] RST_VAL = 32'hA5A5_0001;

    logic        clk;
    logic        rst_n;
    logic [0:31] abus;
    logic [0:3]  be;
    logic [0:31] dbus;
    logic        rnw;
    logic        sel;
    logic        seq_addr;
    logic [0:31] sl_dbus;
    logic        sl_ack;
    logic        sl_err;
    logic        sl_retry;
    logic        sl_tout;
    logic [31:0] user_data;
    logic        user_valid;

    opb_register_ppc2user #(
        .C_BASEADDR    (32'h0100_E200),
        .C_HIGHADDR    (32'h0100_E2FF),
        .C_OPB_AWIDTH  (32),
        .C_OPB_DWIDTH  (32),
        .C_RESET_VALUE (RST_VAL)
    ) dut (
        .OPB_Clk         (clk),
        .OPB_Rst_n       (rst_n),
        .OPB_ABus        (abus),
        .OPB_BE          (be),
        .OPB_DBus        (dbus),
        .OPB_RNW         (rnw),
        .OPB_select      (sel),
        .OPB_seqAddr     (seq_addr),
        .Sl_DBus         (sl_dbus),
        .Sl_xferAck      (sl_ack),
        .Sl_errAck       (sl_err),
        .Sl_retry        (sl_retry),
        .Sl_toutSup      (sl_tout),
        .user_data_out   (user_data),
        .user_data_valid (user_valid)
    );

    typedef struct {
        int          cyc;
        logic        rnw;
        logic [31:0] rdata;
        logic [31:0] udata;
        logic        valid;
    } exp_t;

    exp_t        sb[$];
    int          n_cmp  = 0;
    int          n_fail = 0;
    int          cyc    = 0;
    int          ack_cnt = 0;
    bit          mon_en = 0;
    logic [31:0] model;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h (cycle %0d)", tag, got, exp, cyc);
        end else begin
            $display("ok   %s: %08h (cycle %0d)", tag, got, cyc);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [3:0] b,
                                          input logic [31:0] d);
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++)
            if (b[i]) r[8*i +: 8] = d[8*i +: 8];
        return r;
    endfunction

    always @(negedge clk) begin
        if (mon_en) begin
            if (sl_ack) begin
                ack_cnt++;
                if (sb.size() == 0) begin
                    chk("unexpected_ack", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("ack_latency", 32'(cyc), 32'(e.cyc + 1));
                    if (e.rnw) chk("read_data", sl_dbus, e.rdata);
                    else       chk("write_value", user_data, e.udata);
                    chk("valid_strobe", {31'd0, user_valid}, {31'd0, e.valid});
                end
            end else begin
                chk("idle_dbus", sl_dbus, 32'h0);
                chk("idle_valid", {31'd0, user_valid}, 32'h0);
            end
        end
    end

    task automatic drive(input logic [31:0] a, input logic [3:0] b, input logic [31:0] d,
                         input logic r, input bit expect_hit);
        exp_t e;
        abus = a; be = b; dbus = d; rnw = r; sel = 1'b1;
        if (expect_hit) begin
            if (!r) model = merge(model, b, d);
            e.cyc   = cyc;
            e.rnw   = r;
            e.rdata = model;
            e.udata = model;
            e.valid = !r && (b != 4'b0000);
            sb.push_back(e);
        end
    endtask

    task automatic idle_bus();
        sel = 1'b0; rnw = 1'b0; abus = '0; be = '0; dbus = '0;
    endtask

    task automatic xfer(input logic [31:0] a, input logic [3:0] b, input logic [31:0] d,
                        input logic r, input bit expect_hit);
        @(posedge clk); #1;
        drive(a, b, d, r, expect_hit);
        @(posedge clk); #1;
        idle_bus();
        @(posedge clk);
    endtask

    initial begin
        int acks_before;
        rst_n = 1'b0; seq_addr = 1'b0;
        idle_bus();
        model = RST_VAL;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("reset_value", user_data, RST_VAL);
        chk("reset_ack", {31'd0, sl_ack}, 32'h0);
        chk("reset_valid", {31'd0, user_valid}, 32'h0);
        chk("reset_dbus", sl_dbus, 32'h0);
        chk("const_outs", {29'd0, sl_err, sl_retry, sl_tout}, 32'h0);
        mon_en = 1'b1;

        xfer(32'h0100_E200, 4'b1111, 32'hDEAD_BEEF, 1'b0, 1'b1);
        xfer(32'h0100_E200, 4'b0100, 32'h0011_0000, 1'b0, 1'b1);
        xfer(32'h0100_E240, 4'b0000, 32'hFFFF_FFFF, 1'b0, 1'b1);
        @(negedge clk);
        chk("be0_unchanged", user_data, 32'hDE11_BEEF);

        xfer(32'h0100_E2FC, 4'b0000, 32'h0, 1'b1, 1'b1);

        acks_before = ack_cnt;
        @(posedge clk); #1;
        drive(32'h0100_E300, 4'b1111, 32'h1234_5678, 1'b1, 1'b0);
        repeat (8) @(posedge clk);
        #1 idle_bus();
        drive(32'h0100_E1FF, 4'b1111, 32'h1234_5678, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #1 idle_bus();
        @(negedge clk);
        chk("miss_no_ack", 32'(ack_cnt), 32'(acks_before));
        chk("miss_no_write", user_data, 32'hDE11_BEEF);

        // select held four cycles: only the IDLE-cycle requests are taken
        acks_before = ack_cnt;
        @(posedge clk); #1;
        drive(32'h0100_E200, 4'b1111, 32'h0000_0001, 1'b0, 1'b1);
        @(posedge clk); #1;
        drive(32'h0100_E200, 4'b1111, 32'hFFFF_FFFF, 1'b0, 1'b0);
        @(posedge clk); #1;
        drive(32'h0100_E200, 4'b1111, 32'h0000_0002, 1'b0, 1'b1);
        @(posedge clk); #1;
        drive(32'h0100_E200, 4'b1111, 32'h0000_0002, 1'b0, 1'b0);
        @(posedge clk); #1;
        idle_bus();
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("b2b_ack_count", 32'(ack_cnt - acks_before), 32'd2);
        chk("b2b_final", user_data, 32'h0000_0002);

        // reset lands before the capturing edge: the transfer must vanish
        acks_before = ack_cnt;
        @(posedge clk); #1;
        drive(32'h0100_E200, 4'b1111, 32'h1234_5678, 1'b0, 1'b0);
        #3 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 idle_bus();
        model = RST_VAL;
        @(negedge clk);
        chk("midrst_value", user_data, RST_VAL);
        rst_n = 1'b1;
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("midrst_no_ack", 32'(ack_cnt), 32'(acks_before));
        chk("midrst_after_release", user_data, RST_VAL);

        xfer(32'h0100_E280, 4'b0001, 32'h0000_00AB, 1'b0, 1'b1);
        xfer(32'h0100_E204, 4'b1010, 32'h0, 1'b1, 1'b1);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("post_reset_value", user_data, 32'hA5A5_00AB);
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);

        mon_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
